// File: rtl/mrr_packet_emulator_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mrr_packet_emulator_if                                          |
// | Purpose  : payload word stream in, OOK baseband I/Q sample stream out      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mrr_packet_emulator_if;
    logic [31:0] i_tdata;
    logic        i_tvalid;
    logic        i_tready;
    logic [15:0] o_tdata_i;
    logic [15:0] o_tdata_q;
    logic        o_tvalid;
    logic        o_tlast;
    logic        o_tready;

    // master = the emulator: consumes payload words, sources I/Q samples
    modport master (
        input  i_tdata, i_tvalid, o_tready,
        output i_tready, o_tdata_i, o_tdata_q, o_tvalid, o_tlast
    );

    modport slave (
        output i_tdata, i_tvalid, o_tready,
        input  i_tready, o_tdata_i, o_tdata_q, o_tvalid, o_tlast
    );
endinterface
`default_nettype wire

// File: rtl/mrr_packet_emulator.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mrr_packet_emulator                                             |
// | Purpose  : serialises header, payload and recharge gap into OOK I/Q samples|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mrr_packet_emulator #(
    parameter int HEADER_LEN     = 16,
    parameter int SYM_LEN_WIDTH  = 16,
    parameter int RECHARGE_WIDTH = 15
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      start,
    input  wire logic [HEADER_LEN-1:0]     header_pattern,
    input  wire logic [7:0]                num_payload_bits,
    input  wire logic [SYM_LEN_WIDTH-1:0]  sym_len,
    input  wire logic [SYM_LEN_WIDTH-1:0]  pulse_len,
    input  wire logic [RECHARGE_WIDTH-1:0] recharge_len,
    input  wire logic [15:0]               amplitude,
    mrr_packet_emulator_if.master          bus,
    output logic                           busy,
    output logic                           pkt_done
);
    localparam int HIDX_W = $clog2(HEADER_LEN) + 1;

    localparam logic [2:0] C_IDLE     = 3'd0;
    localparam logic [2:0] C_HEADER   = 3'd1;
    localparam logic [2:0] C_LOAD     = 3'd2;
    localparam logic [2:0] C_PAYLOAD  = 3'd3;
    localparam logic [2:0] C_RECHARGE = 3'd4;

    localparam logic [HIDX_W-1:0]         C_HDR_LAST = HIDX_W'(HEADER_LEN - 1);
    localparam logic [HIDX_W-1:0]         C_HIDX_ONE = HIDX_W'(1);
    localparam logic [SYM_LEN_WIDTH-1:0]  C_SYM_ONE  = SYM_LEN_WIDTH'(1);
    localparam logic [RECHARGE_WIDTH-1:0] C_RC_ONE   = RECHARGE_WIDTH'(1);

    logic [2:0]                state_q, state_d;
    logic [HEADER_LEN-1:0]     hdr_q, hdr_d;
    logic [7:0]                nbits_q, nbits_d;
    logic [SYM_LEN_WIDTH-1:0]  sym_q, sym_d;
    logic [SYM_LEN_WIDTH-1:0]  pulse_q, pulse_d;
    logic [RECHARGE_WIDTH-1:0] rchg_q, rchg_d;
    logic [15:0]               amp_q, amp_d;
    logic [HIDX_W-1:0]         hidx_q, hidx_d;
    logic [SYM_LEN_WIDTH-1:0]  samp_q, samp_d;
    logic [7:0]                pbits_q, pbits_d;
    logic [4:0]                wbit_q, wbit_d;
    logic [31:0]               sr_q, sr_d;
    logic [RECHARGE_WIDTH-1:0] rcnt_q, rcnt_d;
    logic                      vld_q, vld_d;
    logic [15:0]               idat_q, idat_d;
    logic                      last_q, last_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      w_slot;
    logic                      w_hs;
    logic                      w_sym_end;
    logic                      w_on;
    logic [SYM_LEN_WIDTH-1:0]  w_sym_eff;
    logic [SYM_LEN_WIDTH-1:0]  w_pulse_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
            hdr_q   <= '0;
            nbits_q <= '0;
            sym_q   <= '0;
            pulse_q <= '0;
            rchg_q  <= '0;
            amp_q   <= '0;
            hidx_q  <= '0;
            samp_q  <= '0;
            pbits_q <= '0;
            wbit_q  <= '0;
            sr_q    <= '0;
            rcnt_q  <= '0;
            vld_q   <= 1'b0;
            idat_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            nbits_q <= nbits_d;
            sym_q   <= sym_d;
            pulse_q <= pulse_d;
            rchg_q  <= rchg_d;
            amp_q   <= amp_d;
            hidx_q  <= hidx_d;
            samp_q  <= samp_d;
            pbits_q <= pbits_d;
            wbit_q  <= wbit_d;
            sr_q    <= sr_d;
            rcnt_q  <= rcnt_d;
            vld_q   <= vld_d;
            idat_q  <= idat_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The generator runs one sample ahead: it refills the output register
    // whenever that register is empty or being drained this cycle.
    assign w_slot      = ~vld_q | bus.o_tready;
    assign w_hs        = vld_q & bus.o_tready;
    assign w_sym_end   = (samp_q == sym_q - C_SYM_ONE);
    assign w_on        = (samp_q < pulse_q);
    assign w_sym_eff   = (sym_len == '0) ? C_SYM_ONE : sym_len;
    assign w_pulse_eff = (pulse_len > w_sym_eff) ? w_sym_eff : pulse_len;

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        nbits_d = nbits_q;
        sym_d   = sym_q;
        pulse_d = pulse_q;
        rchg_d  = rchg_q;
        amp_d   = amp_q;
        hidx_d  = hidx_q;
        samp_d  = samp_q;
        pbits_d = pbits_q;
        wbit_d  = wbit_q;
        sr_d    = sr_q;
        rcnt_d  = rcnt_q;
        vld_d   = vld_q;
        idat_d  = idat_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (w_hs && last_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        if (w_slot) begin
            vld_d  = 1'b0;
            idat_d = '0;
            last_d = 1'b0;
        end

        case (state_q)
            C_IDLE: begin
                // busy_q still high means the final sample is waiting downstream
                if (start && !busy_q) begin
                    hdr_d   = header_pattern;
                    nbits_d = num_payload_bits;
                    sym_d   = w_sym_eff;
                    pulse_d = w_pulse_eff;
                    rchg_d  = recharge_len;
                    amp_d   = amplitude;
                    hidx_d  = '0;
                    samp_d  = '0;
                    pbits_d = '0;
                    busy_d  = 1'b1;
                    state_d = C_HEADER;
                end
            end
            C_HEADER: if (w_slot) begin
                vld_d  = 1'b1;
                idat_d = (hdr_q[HEADER_LEN-1] && w_on) ? amp_q : '0;
                if (w_sym_end) begin
                    samp_d = '0;
                    hdr_d  = hdr_q << 1;
                    hidx_d = hidx_q + C_HIDX_ONE;
                    if (hidx_q == C_HDR_LAST) begin
                        if (nbits_q != '0) begin
                            state_d = C_LOAD;
                        end else if (rchg_q != '0) begin
                            rcnt_d  = '0;
                            state_d = C_RECHARGE;
                        end else begin
                            last_d  = 1'b1;
                            state_d = C_IDLE;
                        end
                    end
                end else begin
                    samp_d = samp_q + C_SYM_ONE;
                end
            end
            C_LOAD: if (bus.i_tvalid) begin
                sr_d    = bus.i_tdata;
                wbit_d  = '0;
                samp_d  = '0;
                state_d = C_PAYLOAD;
            end
            C_PAYLOAD: if (w_slot) begin
                vld_d  = 1'b1;
                idat_d = (sr_q[31] && w_on) ? amp_q : '0;
                if (w_sym_end) begin
                    samp_d = '0;
                    if (pbits_q == nbits_q - 8'd1) begin
                        if (rchg_q != '0) begin
                            rcnt_d  = '0;
                            state_d = C_RECHARGE;
                        end else begin
                            last_d  = 1'b1;
                            state_d = C_IDLE;
                        end
                    end else begin
                        pbits_d = pbits_q + 8'd1;
                        if (wbit_q == 5'd31) begin
                            state_d = C_LOAD;
                        end else begin
                            sr_d   = sr_q << 1;
                            wbit_d = wbit_q + 5'd1;
                        end
                    end
                end else begin
                    samp_d = samp_q + C_SYM_ONE;
                end
            end
            C_RECHARGE: if (w_slot) begin
                vld_d = 1'b1;
                if (rcnt_q == rchg_q - C_RC_ONE) begin
                    last_d  = 1'b1;
                    state_d = C_IDLE;
                end else begin
                    rcnt_d = rcnt_q + C_RC_ONE;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        bus.i_tready  = (state_q == C_LOAD);
        bus.o_tdata_i = idat_q;
        bus.o_tdata_q = '0;
        bus.o_tvalid  = vld_q;
        bus.o_tlast   = last_q;
        busy          = busy_q;
        pkt_done      = done_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_mrr_packet_emulator.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mrr_packet_emulator                                          |
// | Purpose  : directed self-checking bench for mrr_packet_emulator            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mrr_packet_emulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] header_pattern = '0;
    logic [7:0]  num_payload_bits = '0;
    logic [15:0] sym_len = '0;
    logic [15:0] pulse_len = '0;
    logic [14:0] recharge_len = '0;
    logic [15:0] amplitude = '0;
    logic        busy;
    logic        pkt_done;

    mrr_packet_emulator_if bus ();

    mrr_packet_emulator #(
        .HEADER_LEN     (16),
        .SYM_LEN_WIDTH  (16),
        .RECHARGE_WIDTH (15)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .header_pattern   (header_pattern),
        .num_payload_bits (num_payload_bits),
        .sym_len          (sym_len),
        .pulse_len        (pulse_len),
        .recharge_len     (recharge_len),
        .amplitude        (amplitude),
        .bus              (bus),
        .busy             (busy),
        .pkt_done         (pkt_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output sampler: accepted samples as {last, I}, plus stall stability
    logic [31:0] got_q[$];
    int          got_cyc[$];
    int          dones = 0, done_cyc = 0, stab_err = 0, qnz = 0;
    logic        hold_p = 1'b0, hold_l = 1'b0;
    logic [15:0] hold_d = '0;
    initial forever begin
        @(negedge clk);
        if (hold_p && (bus.o_tvalid !== 1'b1 || bus.o_tdata_i !== hold_d || bus.o_tlast !== hold_l))
            stab_err++;
        hold_p = bus.o_tvalid && !bus.o_tready;
        hold_d = bus.o_tdata_i;
        hold_l = bus.o_tlast;
        if (bus.o_tvalid && bus.o_tready) begin
            got_q.push_back({15'd0, bus.o_tlast, bus.o_tdata_i});
            got_cyc.push_back(cyc);
            if (bus.o_tdata_q !== 16'd0) qnz++;
        end
        if (pkt_done) begin
            dones++;
            done_cyc = cyc;
        end
    end

    bit rand_mode = 1'b0;
    initial begin
        bus.o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.o_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] words [2] = '{32'h8000_0001, 32'hFF00_0000};
    logic [31:0] exp_q[$];
    int          base = 0, done_base = 0, start_cyc = 0;
    int          loads = 0, stall_cyc = 0, stall_vld = 0;
    bit          abort = 1'b0;

    function automatic logic [31:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < got_cyc.size()) ? got_cyc[i] : -100;
    endfunction

    task automatic push_sym(input logic b, input int s, input int p, input int amp);
        for (int k = 0; k < s; k++) exp_q.push_back((b && k < p) ? 32'(amp) : 32'd0);
    endtask

    task automatic build_exp(input logic [15:0] hdr, input int nb, input int sym,
                             input int pls, input int rc, input int amp);
        int s, p;
        logic [31:0] w;
        exp_q.delete();
        s = (sym == 0) ? 1 : sym;
        p = (pls > s) ? s : pls;
        for (int b = 15; b >= 0; b--) push_sym(hdr[b], s, p, amp);
        for (int b = 0; b < nb; b++) begin
            w = words[b / 32];
            push_sym(w[31 - (b % 32)], s, p, amp);
        end
        for (int r = 0; r < rc; r++) exp_q.push_back(32'd0);
        exp_q[exp_q.size() - 1][16] = 1'b1;
    endtask

    task automatic feeder(input int nw, input int stall);
        int idx = 0;
        int st = stall;
        int guard = 0;
        bit hs;
        while (idx < nw && !abort && guard < 4000) begin
            bus.i_tdata  = words[idx];
            bus.i_tvalid = (st == 0);
            @(negedge clk);
            hs = bus.i_tvalid && bus.i_tready;
            if (bus.i_tready && !bus.i_tvalid && st > 0) begin
                st--;
                stall_cyc++;
                if (bus.o_tvalid) stall_vld++;
            end
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                loads++;
            end
            guard++;
        end
        bus.i_tvalid = 1'b0;
    endtask

    // Settings are scrambled right after start to prove they were latched
    task automatic send(input logic [15:0] hdr, input int nb, input int sym,
                        input int pls, input int rc, input int amp);
        @(posedge clk);
        #1;
        header_pattern   = hdr;
        num_payload_bits = 8'(nb);
        sym_len          = 16'(sym);
        pulse_len        = 16'(pls);
        recharge_len     = 15'(rc);
        amplitude        = 16'(amp);
        start            = 1'b1;
        start_cyc        = cyc;
        base             = got_q.size();
        done_base        = dones;
        @(posedge clk);
        #1;
        start          = 1'b0;
        header_pattern = ~hdr;
        amplitude      = 16'hDEAD;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pkt_done && n < budget);
        check_eq("pkt_done_seen", 32'(pkt_done), 32'd1);
    endtask

    task automatic cmp_pkt(input string tag);
        int n;
        n = got_q.size() - base;
        check_eq({tag, "_count"}, 32'(n), 32'(exp_q.size()));
        check_eq({tag, "_done_pulses"}, 32'(dones - done_base), 32'd1);
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check_eq($sformatf("%s_smp%0d", tag, i), got_q[base + i], exp_q[i]);
    endtask

    task automatic run_pkt(input logic [15:0] hdr, input int nb, input int sym, input int pls,
                           input int rc, input int amp, input int nw, input int stall,
                           input string tag);
        build_exp(hdr, nb, sym, pls, rc, amp);
        loads     = 0;
        stall_cyc = 0;
        stall_vld = 0;
        fork
            feeder(nw, stall);
            begin
                send(hdr, nb, sym, pls, rc, amp);
                check_eq({tag, "_busy_up"}, 32'(busy), 32'd1);
                wait_done(3000);
            end
        join
        repeat (2) @(negedge clk);
        cmp_pkt(tag);
    endtask

    initial begin
        int n;
        int stab_base;
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_tvalid", 32'(bus.o_tvalid), 32'd0);
        check_eq("rst_tlast", 32'(bus.o_tlast), 32'd0);
        check_eq("rst_itready", 32'(bus.i_tready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_pkt_done", 32'(pkt_done), 32'd0);
        check_eq("rst_tdata_i", 32'(bus.o_tdata_i), 32'd0);
        check_eq("rst_tdata_q", 32'(bus.o_tdata_q), 32'd0);
        rst_n = 1'b1;

        // 1: header only, 16 symbols x 4 samples
        run_pkt(16'hA5F0, 0, 4, 2, 0, 1000, 0, 0, "t1");
        check_eq("t1_s0", got_at(base + 0), 32'd1000);
        check_eq("t1_s1", got_at(base + 1), 32'd1000);
        check_eq("t1_s2", got_at(base + 2), 32'd0);
        check_eq("t1_s4", got_at(base + 4), 32'd0);
        check_eq("t1_s63_last", got_at(base + 63), 32'h0001_0000);
        check_eq("t1_first_latency", 32'(cyc_at(base) - start_cyc), 32'd2);
        check_eq("t1_done_after_last", 32'(done_cyc - cyc_at(base + 63)), 32'd1);
        check_eq("t1_busy_down", 32'(busy), 32'd0);

        // 2: 40 payload bits over two words, 10-sample recharge: 64+160+10 samples
        run_pkt(16'hA5F0, 40, 4, 2, 10, 1000, 2, 0, "t2");
        check_eq("t2_loads", 32'(loads), 32'd2);
        check_eq("t2_pay_bit0", got_at(base + 64), 32'd1000);
        check_eq("t2_pay_bit1", got_at(base + 68), 32'd0);
        check_eq("t2_pay_bit31", got_at(base + 188), 32'd1000);
        check_eq("t2_pay_bit32", got_at(base + 192), 32'd1000);
        check_eq("t2_pay_bit39_off", got_at(base + 222), 32'd0);
        check_eq("t2_rchg_last", got_at(base + 233), 32'h0001_0000);

        // 3: random downstream back-pressure
        stab_base = stab_err;
        rand_mode = 1'b1;
        run_pkt(16'hA5F0, 40, 4, 2, 10, 1000, 2, 0, "t3");
        rand_mode = 1'b0;
        check_eq("t3_stable_while_stalled", 32'(stab_err - stab_base), 32'd0);

        // 4: first word withheld 20 LOAD cycles; only the trailing header
        // sample is still on the bus during the first of them
        run_pkt(16'hA5F0, 40, 4, 2, 10, 1000, 2, 20, "t4");
        check_eq("t4_stall_cycles", 32'(stall_cyc), 32'd20);
        check_eq("t4_valid_in_stall", 32'(stall_vld), 32'd1);
        check_eq("t4_loads", 32'(loads), 32'd2);

        // 5: asynchronous reset in the middle of the payload
        fork
            feeder(2, 0);
            begin
                send(16'hA5F0, 40, 4, 2, 10, 1000);
                n = 0;
                while (got_q.size() - base < 100 && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                check_eq("t5_reached_payload", 32'(got_q.size() - base >= 100), 32'd1);
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                check_eq("t5_rst_tvalid", 32'(bus.o_tvalid), 32'd0);
                check_eq("t5_rst_tlast", 32'(bus.o_tlast), 32'd0);
                check_eq("t5_rst_tdata_i", 32'(bus.o_tdata_i), 32'd0);
                check_eq("t5_rst_itready", 32'(bus.i_tready), 32'd0);
                check_eq("t5_rst_busy", 32'(busy), 32'd0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        abort = 1'b0;
        run_pkt(16'hA5F0, 40, 4, 2, 10, 1000, 2, 0, "t5");

        // 6: sym_len=0 gives one sample per symbol; a start while busy is ignored
        build_exp(16'hA5F0, 0, 0, 5, 0, 1234);
        send(16'hA5F0, 0, 0, 5, 0, 1234);
        repeat (3) @(posedge clk);
        #1;
        header_pattern = 16'hFFFF;
        start          = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200);
        repeat (30) @(negedge clk);
        cmp_pkt("t6");
        check_eq("t6_s0", got_at(base + 0), 32'd1234);
        check_eq("t6_s1", got_at(base + 1), 32'd0);
        check_eq("t6_first_latency", 32'(cyc_at(base) - start_cyc), 32'd2);
        check_eq("t6_idle_after", 32'(busy), 32'd0);

        check_eq("q_always_zero", 32'(qnz), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
